instr_fetch: RTL

- Instruction fetch unit for the custom MIPS core.
- Owns the program counter and issues word reads to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents them to the control/decode block as `ir`/`ir_pc` under a valid/ready handshake.
- Accepts branch/jump redirects from control: flushes buffered and in-flight instructions, then restarts fetch at the target.

---
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit for the custom MIPS core.
// Owns the program counter, issues single-outstanding word reads to
// instruction memory, buffers returned words in a small prefetch FIFO and
// hands them to control/decode under a valid/ready handshake. Branch/jump
// redirects flush the FIFO, drop any stale in-flight response and restart
// fetch at the target.
// Optional feature: define IFETCH_HALT_EN to stop fetching after a word with
// opcode 6'b111111 is buffered (cleared by a redirect or reset).
`timescale 1ns/1ps

module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        ir_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          outst_q, outst_d;
  logic          drop_q, drop_d;
  logic          halted_q, halted_d;
  logic [31:0]   word_q [FIFO_DEPTH];
  logic [31:0]   word_d [FIFO_DEPTH];
  logic [31:0]   wpc_q  [FIFO_DEPTH];
  logic [31:0]   wpc_d  [FIFO_DEPTH];

  logic rsp_valid;
  logic push;
  logic pop;
  logic accept;
  logic space_ok;
  logic halt_push;
  logic unused_bits;

  // Low target bits are forced to zero, so they never reach any logic.
  assign unused_bits = ^br_target[1:0];

  // Decode this cycle's response, handshake and request eligibility.
  always_comb begin
    rsp_valid = imem_rvalid && outst_q;
    push      = rsp_valid && !drop_q && !br_taken;
`ifdef IFETCH_HALT_EN
    halt_push = push && (imem_rdata[31:26] == 6'b111111);
`else
    halt_push = 1'b0;
`endif
    space_ok  = (({1'b0, count_q} + {{CW{1'b0}}, outst_q}) < (CW+1)'(FIFO_DEPTH));
    imem_req  = rst_n && !br_taken && !halted_q && !halt_push &&
                (!outst_q || imem_rvalid) && space_ok;
    imem_addr = imem_req ? pc_q : 32'h0;
    accept    = imem_req && imem_gnt;
    ir_valid  = (count_q != '0);
    pop       = ir_valid && ir_ready && !br_taken;
    ir        = ir_valid ? word_q[rd_ptr_q] : 32'h0;
    ir_pc     = ir_valid ? wpc_q[rd_ptr_q]  : 32'h0;
  end

  // Next-state for PC, in-flight tracking and FIFO; a redirect overrides all.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    halted_d = halted_q;
    word_d   = word_q;
    wpc_d    = wpc_q;

    if (accept) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
      outst_d  = 1'b1;
    end else if (rsp_valid) begin
      outst_d = 1'b0;
    end

    if (rsp_valid && drop_q) begin
      drop_d = 1'b0;
    end

    if (push) begin
      word_d[wr_ptr_q] = imem_rdata;
      wpc_d[wr_ptr_q]  = req_pc_q;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (halt_push) begin
      halted_d = 1'b1;
    end

    if (br_taken) begin
      pc_d     = {br_target[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = outst_q && !imem_rvalid;
      halted_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      outst_q  <= 1'b0;
      drop_q   <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_q[i] <= 32'h0;
        wpc_q[i]  <= 32'h0;
      end
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
      word_q   <= word_d;
      wpc_q    <= wpc_d;
    end
  end

endmodule
